// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_ctrl
// Brief   : Byte-serial RAM/IO port arbiter for load/store buffer and fetcher;
//           splits or assembles 1/2/4-byte little-endian transfers.
// Revision: 1.0
// ============================================================================
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        lsb_r_en,
  input  logic        lsb_w_en,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_val,
  input  logic [31:0] lsb_len,
  output logic        lsb_done,
  output logic [31:0] lsb_data,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_read  = 2'd1;
  localparam logic [1:0] c_write = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [2:0]  r_len;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rbuf;
  logic        r_owner_if;
  logic        r_is_write;
  logic [31:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic        r_mem_wr;
  logic        r_lsb_done;
  logic        r_if_done;
  logic [31:0] r_lsb_data;
  logic [31:0] r_if_inst;

  logic        w_req;
  logic [2:0]  w_lsb_len;
  logic [31:0] w_cur_addr;
  logic        w_stall;
  logic [1:0]  w_cap_idx;
  logic [7:0]  w_wr_byte;
  logic [31:0] w_rd_word;

  assign w_req      = lsb_w_en | lsb_r_en | if_en;
  assign w_lsb_len  = (lsb_len == 32'd1) ? 3'd1 :
                      (lsb_len == 32'd2) ? 3'd2 : 3'd4;
  assign w_cur_addr = r_addr + {29'd0, r_cnt};
  assign w_stall    = (w_cur_addr >= IO_BASE) && io_buffer_full;
  // Byte captured at counter k belongs to the address issued at k-1.
  assign w_cap_idx  = r_cnt[1:0] - 2'd1;

  always_comb begin
    w_wr_byte = r_wdata[7:0];
    case (r_cnt[1:0])
      2'd0:    w_wr_byte = r_wdata[7:0];
      2'd1:    w_wr_byte = r_wdata[15:8];
      2'd2:    w_wr_byte = r_wdata[23:16];
      default: w_wr_byte = r_wdata[31:24];
    endcase
  end

  always_comb begin
    w_rd_word = r_rbuf;
    case (w_cap_idx)
      2'd0:    w_rd_word[7:0]   = mem_din;
      2'd1:    w_rd_word[15:8]  = mem_din;
      2'd2:    w_rd_word[23:16] = mem_din;
      default: w_rd_word[31:24] = mem_din;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= c_idle;
      r_cnt      <= 3'd0;
      r_len      <= 3'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rbuf     <= 32'd0;
      r_owner_if <= 1'b0;
      r_is_write <= 1'b0;
      r_mem_a    <= 32'd0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_lsb_done <= 1'b0;
      r_if_done  <= 1'b0;
      r_lsb_data <= 32'd0;
      r_if_inst  <= 32'd0;
    end else if (rdy_in) begin
      case (r_state)
        c_idle: begin
          r_mem_wr   <= 1'b0;
          r_lsb_done <= 1'b0;
          r_if_done  <= 1'b0;
          if (w_req && !clear) begin
            r_cnt  <= 3'd0;
            r_rbuf <= 32'd0;
            if (lsb_w_en) begin
              r_state    <= c_write;
              r_owner_if <= 1'b0;
              r_is_write <= 1'b1;
              r_addr     <= lsb_addr;
              r_len      <= w_lsb_len;
              r_wdata    <= lsb_val;
            end else if (lsb_r_en) begin
              r_state    <= c_read;
              r_owner_if <= 1'b0;
              r_is_write <= 1'b0;
              r_addr     <= lsb_addr;
              r_len      <= w_lsb_len;
            end else begin
              r_state    <= c_read;
              r_owner_if <= 1'b1;
              r_is_write <= 1'b0;
              r_addr     <= if_addr;
              r_len      <= 3'd4;
            end
          end
        end

        c_read: begin
          if (clear) begin
            r_state <= c_idle;
            r_cnt   <= 3'd0;
          end else begin
            if (r_cnt != 3'd0) begin
              r_rbuf <= w_rd_word;
            end
            if (r_cnt == r_len) begin
              r_state <= c_done;
              if (r_owner_if) begin
                r_if_done <= 1'b1;
                r_if_inst <= w_rd_word;
              end else begin
                r_lsb_done <= 1'b1;
                r_lsb_data <= w_rd_word;
              end
            end else begin
              r_mem_a  <= w_cur_addr;
              r_mem_wr <= 1'b0;
              r_cnt    <= r_cnt + 3'd1;
            end
          end
        end

        // Stores are already committed, so clear is ignored here.
        c_write: begin
          if (w_stall) begin
            r_mem_wr <= 1'b0;
          end else begin
            r_mem_a    <= w_cur_addr;
            r_mem_dout <= w_wr_byte;
            r_mem_wr   <= 1'b1;
            r_cnt      <= r_cnt + 3'd1;
            if (r_cnt == r_len - 3'd1) begin
              r_lsb_done <= 1'b1;
              r_state    <= c_done;
            end
          end
        end

        default: begin
          r_mem_wr   <= 1'b0;
          r_lsb_done <= 1'b0;
          r_if_done  <= 1'b0;
          r_cnt      <= 3'd0;
          r_state    <= c_idle;
        end
      endcase
    end
  end

  // A flushed pipeline must not see a read result in the DONE cycle.
  assign lsb_done = r_lsb_done & rdy_in & ~(clear & ~r_is_write);
  assign if_done  = r_if_done & rdy_in & ~clear;
  assign mem_wr   = r_mem_wr & rdy_in;
  assign mem_a    = r_mem_a;
  assign mem_dout = r_mem_dout;
  assign lsb_data = r_lsb_data;
  assign if_inst  = r_if_inst;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_ctrl
// Brief   : Self-checking bench for mem_ctrl with a byte-array RAM and a
//           transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        lsb_r_en = 1'b0;
  logic        lsb_w_en = 1'b0;
  logic [31:0] lsb_addr = 32'd0;
  logic [31:0] lsb_val = 32'd0;
  logic [31:0] lsb_len = 32'd0;
  logic        lsb_done;
  logic [31:0] lsb_data;
  logic        if_en = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_done;
  logic [31:0] if_inst;

  mem_ctrl #(.IO_BASE(32'h0003_0000)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clear          (clear),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .lsb_r_en       (lsb_r_en),
    .lsb_w_en       (lsb_w_en),
    .lsb_addr       (lsb_addr),
    .lsb_val        (lsb_val),
    .lsb_len        (lsb_len),
    .lsb_done       (lsb_done),
    .lsb_data       (lsb_data),
    .if_en          (if_en),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_inst        (if_inst)
  );

  always #5 clk_in = ~clk_in;

  // RAM aliases on the low 16 address bits; reads are combinational.
  logic [7:0]  ram   [0:65535];
  logic [7:0]  model [0:65535];
  logic [31:0] wlog_a [$];
  logic [7:0]  wlog_d [$];

  assign mem_din = ram[mem_a[15:0]];

  always @(posedge clk_in) begin
    if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input int len);
    logic [31:0] v;
    logic [31:0] ad;
    v = 32'd0;
    for (int k = 0; k < len; k++) begin
      ad = a + k;
      v[8*k +: 8] = model[ad[15:0]];
    end
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] v, input int len);
    logic [31:0] ad;
    for (int k = 0; k < len; k++) begin
      ad = a + k;
      model[ad[15:0]] = v[8*k +: 8];
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  bit          t_l_act, t_l_wr, t_f_act;
  logic [31:0] t_addr, t_val, t_f_addr;
  int          t_len;
  int          g_l_at, g_f_at;
  logic [31:0] g_l_got, g_f_got;

  task automatic start_req(input bit l_act, input bit l_wr, input logic [31:0] a,
                           input logic [31:0] v, input int len,
                           input bit f_act, input logic [31:0] fa);
    t_l_act = l_act; t_l_wr = l_wr; t_addr = a; t_val = v; t_len = len;
    t_f_act = f_act; t_f_addr = fa;
    wlog_a.delete();
    wlog_d.delete();
    lsb_addr = a;
    lsb_val  = v;
    lsb_len  = len;
    lsb_w_en = l_act & l_wr;
    lsb_r_en = l_act & ~l_wr;
    if_addr  = fa;
    if_en    = f_act;
  endtask

  // Requesters drop their enable on the edge after seeing done.
  task automatic run_txn();
    int cyc = 0;
    int l_seen = 0;
    int f_seen = 0;
    int l_at = 0;
    int f_at = 0;
    bit l_now, f_now;
    logic [31:0] l_got = 32'd0;
    logic [31:0] f_got = 32'd0;
    logic [7:0]  eb;
    while ((lsb_r_en || lsb_w_en || if_en) && cyc < 200) begin
      @(negedge clk_in);
      cyc++;
      l_now = lsb_done;
      f_now = if_done;
      if (l_now) begin l_seen++; l_got = lsb_data; l_at = cyc; end
      if (f_now) begin f_seen++; f_got = if_inst; f_at = cyc; end
      step();
      if (l_now) begin lsb_r_en = 1'b0; lsb_w_en = 1'b0; end
      if (f_now) if_en = 1'b0;
    end
    check("txn_timeout", {31'd0, lsb_r_en | lsb_w_en | if_en}, 32'd0);
    lsb_r_en = 1'b0; lsb_w_en = 1'b0; if_en = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      if (lsb_done) l_seen++;
      if (if_done) f_seen++;
    end
    if (t_l_act) begin
      check("lsb_done_count", l_seen, 1);
      if (t_l_wr) begin
        check("wr_count", wlog_a.size(), t_len);
        for (int k = 0; k < t_len && k < wlog_a.size(); k++) begin
          eb = t_val[8*k +: 8];
          check("wr_addr", wlog_a[k], t_addr + k);
          check("wr_data", {24'd0, wlog_d[k]}, {24'd0, eb});
        end
        model_store(t_addr, t_val, t_len);
      end else begin
        check("lsb_data", l_got, model_load(t_addr, t_len));
      end
    end
    if (!(t_l_act && t_l_wr)) check("no_write", wlog_a.size(), 0);
    if (t_f_act) begin
      check("if_done_count", f_seen, 1);
      check("if_inst", f_got, model_load(t_f_addr, 4));
    end
    if (t_l_act && t_f_act) check("fetch_gap", f_at - l_at, 7);
    g_l_at = l_at; g_f_at = f_at; g_l_got = l_got; g_f_got = f_got;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int kind, lsel, rlen, n;
    logic [31:0] ra, rfa;
    logic [7:0]  b;

    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      ram[i] <= b;
      model[i] = b;
    end
    ram[16'h0100] <= 8'h13; model[16'h0100] = 8'h13;
    ram[16'h0101] <= 8'h05; model[16'h0101] = 8'h05;
    ram[16'h0102] <= 8'h00; model[16'h0102] = 8'h00;
    ram[16'h0103] <= 8'h00; model[16'h0103] = 8'h00;
    ram[16'h0080] <= 8'h80; model[16'h0080] = 8'h80;

    repeat (2) step();
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_lsb_data", lsb_data, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    rst_in = 1'b0;

    // Plain fetch with exact latency.
    step();
    start_req(1'b0, 1'b0, 32'd0, 32'd0, 0, 1'b1, 32'h100);
    run_txn();
    check("fetch_latency", g_f_at, 7);
    check("fetch_word", g_f_got, 32'h0000_0513);

    // Load and fetch raised together: LSB first.
    step();
    start_req(1'b1, 1'b0, 32'h40, 32'd0, 4, 1'b1, 32'h104);
    run_txn();
    check("lsb_before_if", {31'd0, g_l_at < g_f_at}, 32'd1);

    // Halfword store.
    step();
    start_req(1'b1, 1'b1, 32'h200, 32'hAABB_CCDD, 2, 1'b0, 32'd0);
    run_txn();

    // Byte load is zero-extended.
    step();
    start_req(1'b1, 1'b0, 32'h80, 32'd0, 1, 1'b0, 32'd0);
    run_txn();
    check("lb_zero_ext", g_l_got, 32'h0000_0080);

    // IO-window store stalled by a full UART buffer.
    step();
    io_buffer_full = 1'b1;
    start_req(1'b1, 1'b1, 32'h0003_0000, 32'h0000_005A, 1, 1'b0, 32'd0);
    n = 0;
    repeat (4) begin
      @(negedge clk_in);
      if (mem_wr) n++;
      if (lsb_done) n++;
    end
    check("io_stall_quiet", n, 0);
    step();
    io_buffer_full = 1'b0;
    run_txn();

    // Flush during a fetch at byte 2.
    step();
    start_req(1'b0, 1'b0, 32'd0, 32'd0, 0, 1'b1, 32'h200);
    repeat (3) step();
    clear = 1'b1;
    if_en = 1'b0;
    step();
    clear = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (if_done || lsb_done) n++;
    end
    check("clr_fetch_no_done", n, 0);
    check("clr_fetch_no_write", wlog_a.size(), 0);

    // Flush during a word store at byte 1: store still completes.
    step();
    start_req(1'b1, 1'b1, 32'h300, 32'h1122_3344, 4, 1'b0, 32'd0);
    repeat (2) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    run_txn();

    // Global enable low mid-store.
    step();
    start_req(1'b1, 1'b1, 32'h400, 32'hCAFE_F00D, 4, 1'b0, 32'd0);
    repeat (2) step();
    rdy_in = 1'b0;
    n = 0;
    repeat (2) begin
      @(negedge clk_in);
      if (mem_wr) n++;
      step();
    end
    rdy_in = 1'b1;
    check("rdy_low_no_wr", n, 0);
    run_txn();

    // Address wrap at 2^32.
    step();
    start_req(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd0, 4, 1'b0, 32'd0);
    run_txn();

    // Asynchronous reset mid-fetch.
    step();
    start_req(1'b0, 1'b0, 32'd0, 32'd0, 0, 1'b1, 32'h100);
    repeat (3) step();
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_mem_a", mem_a, 32'd0);
    check("arst_if_inst", if_inst, 32'd0);
    if_en = 1'b0;
    step();
    rst_in = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (if_done || lsb_done) n++;
    end
    check("arst_no_done", n, 0);

    // Randomized transactions.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      lsel = $urandom_range(0, 2);
      rlen = (lsel == 0) ? 1 : (lsel == 1) ? 2 : 4;
      ra   = 32'($urandom_range(0, 32'h0000_FFF0));
      rfa  = 32'($urandom_range(0, 32'h0000_FFFC)) & 32'hFFFF_FFFC;
      step();
      io_buffer_full = 1'($urandom_range(0, 1));
      case (kind)
        0:       start_req(1'b1, 1'b1, ra, $urandom, rlen, 1'b0, 32'd0);
        1:       start_req(1'b1, 1'b0, ra, 32'd0, rlen, 1'b0, 32'd0);
        2:       start_req(1'b0, 1'b0, 32'd0, 32'd0, 0, 1'b1, rfa);
        default: start_req(1'b1, 1'b0, ra, 32'd0, rlen, 1'b1, rfa);
      endcase
      run_txn();
      io_buffer_full = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller directly downstream of the load/store buffer and the instruction fetcher.
- Arbitrates between them for the single 8-bit RAM/IO port.
- Assembles or splits 1/2/4-byte little-endian transfers and returns one done pulse per accepted request.
- LSB requests have priority over fetch.

Parameters:
- IO_BASE, 32'h00030000, lowest address of the memory-mapped IO window.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset; asynchronous, active-high
- rdy_in  input  1  global enable; low freezes all state
- clear  input  1  pipeline flush from ROB
- io_buffer_full  input  1  UART buffer full; stalls IO-window writes
- mem_din  input  8  RAM read byte
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  write strobe; 1 = write
- lsb_r_en  input  1  LSB load request
- lsb_w_en  input  1  LSB store request
- lsb_addr  input  32  LSB byte address
- lsb_val  input  32  store data, low bytes used
- lsb_len  input  32  transfer length: 1, 2 or 4
- lsb_done  output  1  one-cycle completion pulse to LSB
- lsb_data  output  32  load result, zero-extended; valid with lsb_done
- if_en  input  1  fetch request
- if_addr  input  32  fetch address (word)
- if_done  output  1  one-cycle completion pulse to fetcher
- if_inst  output  32  fetched word; valid with if_done

Behaviour:
- Reset (async, rst_in=1): all outputs 0; state IDLE; byte counter 0; no latched request.

States:
- IDLE: accept one request. Precedence is lsb_w_en, then lsb_r_en, then if_en.
  - Latch address, length (fetch = 4), write data and owner (LSB/IF).
  - Go to WRITE or READ; counter = 0.
- READ:
  - Edge with counter = k < len: mem_a <= addr+k, mem_wr <= 0.
  - RAM latency is 1 cycle: the byte addressed at edge k is captured from mem_din at edge k+1 into bits [8(k)+7 : 8k].
  - Total len+1 cycles in READ.
  - After the final capture, pulse the owner's done, drive its data, go to DONE.
  - Unused upper bytes are 0.
- WRITE:
  - Per edge: mem_a <= addr+k, mem_dout <= byte k of the value, mem_wr <= 1, k++.
  - After byte len-1 is written: mem_wr <= 0, pulse lsb_done, go to DONE.
  - Takes len cycles.
- Write stall: if addr >= IO_BASE and io_buffer_full = 1, hold the counter and drive mem_wr = 0 until it clears.
- DONE:
  - One cycle. Done pulses drop to 0. All requests are ignored, because requesters drop en only on the edge after seeing done.
  - Then IDLE.
- Outputs when not transferring: mem_wr = 0; mem_a holds its last value; done pulses are exactly one cycle wide.
- clear:
  - In READ, or in IDLE with a request present: abort to IDLE; no done pulse; the read is discarded.
  - WRITE always completes (the store is already committed), including its lsb_done pulse.
  - A DONE cycle carrying a read result is suppressed: done is forced to 0.
- rdy_in = 0: state, counter and outputs freeze, except mem_wr forced to 0 to prevent duplicate writes. The transfer resumes at the same byte when rdy_in returns.
- Simultaneous lsb_r_en and if_en in IDLE: LSB wins; fetch stays pending and is served after DONE.
- Address arithmetic is mod 2^32.
- Async reset mid-transfer abandons it immediately; no done is ever issued for it.

Test Plan:
- Fetch: if_addr=0x100, RAM bytes 0x13,0x05,0x00,0x00 -> after 5 READ cycles, one-cycle if_done with if_inst=0x00000513; then one DONE cycle.
- LSB lw vs fetch in the same IDLE cycle -> LSB served first (lsb_done, lsb_data=word); fetch starts 1 cycle after DONE and completes with the correct word.
- sh: lsb_addr=0x200, lsb_val=0xAABBCCDD, len=2 -> mem_wr=1 for exactly 2 cycles, bytes 0xDD@0x200 and 0xCC@0x201; lsb_done pulse; no write to 0x202.
- lb from a byte holding 0x80 -> lsb_data=0x00000080 (zero-extended).
- IO stall: sb to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 during the stall, a single write of the byte after release, then lsb_done.
- clear during a 4-byte fetch at byte 2 -> no if_done, return to IDLE. clear during a sw at byte 1 -> all 4 bytes written and lsb_done still pulsed.
- rdy_in low for 2 cycles mid-write -> no extra mem_wr pulses; written byte sequence unchanged.
